// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small opcode-decoding helpers.
package md_unit_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   typedef enum logic [2:0] {
      MD_S_IDLE = 3'd0,
      MD_S_MUL  = 3'd1,
      MD_S_DIV  = 3'd2,
      MD_S_FIX  = 3'd3,
      MD_S_DONE = 3'd4
   } md_state_e;

   function automatic logic md_is_mul(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle,
// WIDTH cycles per divide. finish is high during the last iteration cycle.
module md_div_core
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             finish_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // The quotient register doubles as the dividend shift register.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = CW'(WIDTH);
         run_d = 1'b1;
      end else if (run_q) begin
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q - CW'(1);
         run_d = (cnt_q != CW'(1));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign finish_o    = run_q && (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Multiply takes one MUL cycle,
// divide runs the restoring core then a FIX cycle for signs and corner cases.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e        state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;

   logic             accept;
   logic             sgn_in;
   logic [WIDTH-1:0] mag1, mag2;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;
   logic             div_finish;
   logic             div_by_zero, min_by_neg1;

   md_div_core #(.WIDTH(WIDTH)) u_div (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (accept && md_is_div(op)),
      .abort_i     (cancel),
      .dividend_i  (mag1),
      .divisor_i   (mag2),
      .quotient_o  (quo),
      .remainder_o (rem),
      .finish_o    (div_finish)
   );

   always_comb begin
      accept = (state_q == MD_S_IDLE) && op_valid && !cancel;
      sgn_in = md_is_signed(op);
      mag1   = (sgn_in && src1[WIDTH-1]) ? -src1 : src1;
      mag2   = (sgn_in && src2[WIDTH-1]) ? -src2 : src2;
   end

   // Sign-extending to 2*WIDTH lets one multiplier serve both MULT and MULTU.
   always_comb begin
      mul_a = {{WIDTH{md_is_signed(op_q) & a_q[WIDTH-1]}}, a_q};
      mul_b = {{WIDTH{md_is_signed(op_q) & b_q[WIDTH-1]}}, b_q};
      prod  = mul_a * mul_b;
   end

   always_comb begin
      quo_fix     = qneg_q ? -quo : quo;
      rem_fix     = rneg_q ? -rem : rem;
      div_by_zero = (b_q == '0);
      min_by_neg1 = md_is_signed(op_q) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         MD_S_IDLE: begin
            if (accept) begin
               op_d   = op;
               a_d    = src1;
               b_d    = src2;
               qneg_d = sgn_in && (src1[WIDTH-1] ^ src2[WIDTH-1]);
               rneg_d = sgn_in && src1[WIDTH-1];
               if (md_is_mul(op)) begin
                  state_d = MD_S_MUL;
               end else if (md_is_div(op)) begin
                  state_d = MD_S_DIV;
               end else begin
                  if (op == MD_OP_MTHI) hi_d = src1;
                  if (op == MD_OP_MTLO) lo_d = src1;
                  state_d = MD_S_DONE;
               end
            end
         end
         MD_S_MUL: begin
            if (cancel) begin
               state_d = MD_S_IDLE;
            end else begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               state_d = MD_S_DONE;
            end
         end
         MD_S_DIV: begin
            if (cancel)          state_d = MD_S_IDLE;
            else if (div_finish) state_d = MD_S_FIX;
         end
         MD_S_FIX: begin
            if (cancel) begin
               state_d = MD_S_IDLE;
            end else begin
               if (div_by_zero) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else if (min_by_neg1) begin
                  lo_d = a_q;
                  hi_d = '0;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
               state_d = MD_S_DONE;
            end
         end
         MD_S_DONE: state_d = MD_S_IDLE;
         default:   state_d = MD_S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= MD_S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign op_ready = (state_q == MD_S_IDLE);
   assign busy     = !op_ready;
   assign done     = (state_q == MD_S_DONE) && !cancel;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: 32-bit and 8-bit instances, hand-computed results,
// latency, cancel and reset behaviour.
module tb_md_unit;
   import md_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;

   logic        v32 = 1'b0, c32 = 1'b0;
   logic [2:0]  op32 = '0;
   logic [31:0] s1_32 = '0, s2_32 = '0;
   logic        ready32, busy32, done32;
   logic [31:0] hi32, lo32;

   logic        v8 = 1'b0, c8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [7:0]  s1_8 = '0, s2_8 = '0;
   logic        ready8, busy8, done8;
   logic [7:0]  hi8, lo8;

   int n_total = 0;
   int n_pass  = 0;
   int lat;
   int seen;

   always #5 clk = ~clk;

   md_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .resetn(resetn), .op_valid(v32), .op_ready(ready32), .op(op32),
      .src1(s1_32), .src2(s2_32), .cancel(c32), .busy(busy32), .done(done32),
      .hi(hi32), .lo(lo32)
   );

   md_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .resetn(resetn), .op_valid(v8), .op_ready(ready8), .op(op8),
      .src1(s1_8), .src2(s2_8), .cancel(c8), .busy(busy8), .done(done8),
      .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l);
      @(negedge clk);
      op32 = o; s1_32 = a; s2_32 = b; v32 = 1'b1;
      @(posedge clk);
      #1 v32 = 1'b0; s1_32 = 32'hDEAD_BEEF; s2_32 = 32'h1234_5678;
      l = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (done32) begin l = k; break; end
      end
      $display("w32 op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi32, lo32, l);
   endtask

   task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int l);
      @(negedge clk);
      op8 = o; s1_8 = a; s2_8 = b; v8 = 1'b1;
      @(posedge clk);
      #1 v8 = 1'b0; s1_8 = 8'h5A; s2_8 = 8'hA5;
      l = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (done8) begin l = k; break; end
      end
      $display("w8  op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi8, lo8, l);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hi", 64'(hi32), 64'h0);
      chk("rst_lo", 64'(lo32), 64'h0);
      chk("rst_ready", 64'(ready32), 64'h1);
      chk("rst_busy", 64'(busy32), 64'h0);
      chk("rst_done", 64'(done32), 64'h0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rel_ready", 64'(ready32), 64'h1);
      chk("rel_done", 64'(done32), 64'h0);

      run32(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
      chk("mult_lat", 64'(lat), 64'd2);
      chk("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo32), 64'hFFFF_FFFA);
      chk("mult_rdy_in_done", 64'(ready32), 64'h0);
      chk("mult_busy_in_done", 64'(busy32), 64'h1);
      @(negedge clk);
      chk("mult_rdy_after", 64'(ready32), 64'h1);

      run32(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, lat);
      chk("multu_lat", 64'(lat), 64'd2);
      chk("multu_hi", 64'(hi32), 64'h2);
      chk("multu_lo", 64'(lo32), 64'hFFFF_FFFA);

      run32(3'd6, 32'h0BAD_0BAD, 32'h1, lat);
      chk("op6_lat", 64'(lat), 64'd1);
      chk("op6_hi", 64'(hi32), 64'h2);
      chk("op6_lo", 64'(lo32), 64'hFFFF_FFFA);

      run32(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
      chk("div_lat", 64'(lat), 64'd34);
      chk("div_lo", 64'(lo32), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi32), 64'hFFFF_FFFF);

      run32(MD_OP_DIVU, 32'd7, 32'd2, lat);
      chk("divu_lo", 64'(lo32), 64'd3);
      chk("divu_hi", 64'(hi32), 64'd1);

      run32(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("minneg_lo", 64'(lo32), 64'h8000_0000);
      chk("minneg_hi", 64'(hi32), 64'h0);

      run32(MD_OP_DIVU, 32'd5, 32'd0, lat);
      chk("divu0_lat", 64'(lat), 64'd34);
      chk("divu0_lo", 64'(lo32), 64'hFFFF_FFFF);
      chk("divu0_hi", 64'(hi32), 64'd5);

      run32(MD_OP_DIV, 32'hFFFF_FFF9, 32'd0, lat);
      chk("div0_lo", 64'(lo32), 64'hFFFF_FFFF);
      chk("div0_hi", 64'(hi32), 64'hFFFF_FFF9);

      run32(MD_OP_DIV, 32'd100, 32'hFFFF_FFF9, lat);
      chk("div_pos_neg_lo", 64'(lo32), 64'hFFFF_FFF2);
      chk("div_pos_neg_hi", 64'(hi32), 64'd2);

      run32(MD_OP_MTHI, 32'h11, 32'h0, lat);
      chk("mthi_lat", 64'(lat), 64'd1);
      chk("mthi_hi", 64'(hi32), 64'h11);
      run32(MD_OP_MTLO, 32'h22, 32'h0, lat);
      chk("mtlo_lo", 64'(lo32), 64'h22);
      chk("mtlo_hi_kept", 64'(hi32), 64'h11);

      // DIVU 9/4 cancelled during cycle t0+10
      @(negedge clk);
      op32 = MD_OP_DIVU; s1_32 = 32'd9; s2_32 = 32'd4; v32 = 1'b1;
      @(posedge clk);
      #1 v32 = 1'b0;
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done32) seen++;
         if (k == 10) c32 = 1'b1;
      end
      @(posedge clk);
      #1 c32 = 1'b0;
      @(negedge clk);
      chk("cancel_ready", 64'(ready32), 64'h1);
      chk("cancel_hi", 64'(hi32), 64'h11);
      chk("cancel_lo", 64'(lo32), 64'h22);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done32) seen++;
      end
      chk("cancel_no_done", 64'(seen), 64'd0);
      $display("w32 DIVU 9/4 cancelled -> hi=%h lo=%h", hi32, lo32);

      // MTHI presented with cancel high must be refused
      op32 = MD_OP_MTHI; s1_32 = 32'h33; v32 = 1'b1; c32 = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("refused_ready", 64'(ready32), 64'h1);
      chk("refused_done", 64'(done32), 64'h0);
      chk("refused_hi", 64'(hi32), 64'h11);
      c32 = 1'b0;
      @(posedge clk);
      #1 v32 = 1'b0;
      @(negedge clk);
      chk("reaccept_done", 64'(done32), 64'h1);
      chk("reaccept_hi", 64'(hi32), 64'h33);
      $display("w32 MTHI 0x33 refused then accepted -> hi=%h", hi32);

      run8(MD_OP_DIV, 8'h81, 8'h03, lat);
      chk("w8_div_lat", 64'(lat), 64'd10);
      chk("w8_div_lo", 64'(lo8), 64'hD6);
      chk("w8_div_hi", 64'(hi8), 64'hFF);
      run8(MD_OP_DIVU, 8'h81, 8'h03, lat);
      chk("w8_divu_lo", 64'(lo8), 64'h2B);
      chk("w8_divu_hi", 64'(hi8), 64'h00);
      run8(MD_OP_MULT, 8'h81, 8'h03, lat);
      chk("w8_mult_hi", 64'(hi8), 64'hFE);
      chk("w8_mult_lo", 64'(lo8), 64'h83);

      // Reset asserted in the middle of a DIVU
      @(negedge clk);
      op32 = MD_OP_DIVU; s1_32 = 32'd100; s2_32 = 32'd7; v32 = 1'b1;
      @(posedge clk);
      #1 v32 = 1'b0;
      repeat (5) @(negedge clk);
      chk("middiv_busy_before", 64'(busy32), 64'h1);
      resetn = 1'b0;
      #1;
      chk("middiv_ready", 64'(ready32), 64'h1);
      chk("middiv_busy", 64'(busy32), 64'h0);
      chk("middiv_hi", 64'(hi32), 64'h0);
      chk("middiv_lo", 64'(lo32), 64'h0);
      chk("middiv_w8_hi", 64'(hi8), 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done32) seen++;
      end
      chk("middiv_no_done", 64'(seen), 64'd0);
      $display("w32 DIVU 100/7 reset mid-flight -> hi=%h lo=%h", hi32, lo32);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
